// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared bus layouts, widths and divider state encoding for the EX stage
package ex_stage_pkg;
  localparam int ID_BUS_LEN = 158;
  localparam int EX_BUS_LEN = 76;
  localparam int EX_FWD_LEN = 39;
  localparam int ST_B = 0;
  localparam int ST_H = 1;
  localparam int ST_W = 2;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;
  typedef struct packed {
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        mul;
    logic        div;
    logic [31:0] rkd;
    logic        mem_en;
    logic [2:0]  st_ctrl;
    logic [4:0]  ld_ctrl;
    logic        rf_we;
    logic        res_from_mem;
    logic [4:0]  waddr;
    logic [31:0] pc;
  } id_bus_t;
endpackage

// File: rtl/ex_stage_div.sv
// ex_stage_div: iterative restoring divider, one quotient bit per cycle, with its own FSM.
//  clk, reset     : clock, async active-high reset (aborts any division in flight)
//  start          : instruction in EX needs a division (sampled only in IDLE)
//  sgn            : signed operation (div.w / mod.w)
//  ack            : downstream accepted the result; DONE returns to IDLE
//  a, b           : dividend, divisor
//  done           : quotient/remainder valid and held
//  quotient, remainder : sign-corrected results
//  Optional DIV_EARLY_TERM_EN: skip CALC when |b| > |a| or b == 0.
module ex_stage_div import ex_stage_pkg::*; #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic             ack,
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);
  localparam int CW = $clog2(DIV_W);
  div_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DIV_W-1:0] q, r, d, abs_a, abs_b, r_next;
  logic [DIV_W:0] shifted;
  logic neg_q, neg_r, dz, early, ge, last;
  assign abs_a = (sgn & a[DIV_W-1]) ? -a : a;
  assign abs_b = (sgn & b[DIV_W-1]) ? -b : b;
`ifdef DIV_EARLY_TERM_EN
  assign early = (abs_b > abs_a) | (b == '0);
`else
  assign early = 1'b0;
`endif
  // Partial remainder shifted left with the next dividend bit; the trial result is below d, so W bits suffice.
  assign shifted = {r, q[DIV_W-1]};
  assign ge = shifted >= {1'b0, d};
  assign r_next = ge ? shifted[DIV_W-1:0] - d : shifted[DIV_W-1:0];
  assign last = cnt == CW'(DIV_W - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      DIV_IDLE: state_n = start ? (early ? DIV_DONE : DIV_CALC) : DIV_IDLE;
      DIV_CALC: state_n = last ? DIV_DONE : DIV_CALC;
      DIV_DONE: state_n = ack ? DIV_IDLE : DIV_DONE;
      default:  state_n = DIV_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DIV_IDLE && start) begin
        cnt   <= '0;
        q     <= early ? '0 : abs_a;
        r     <= early ? abs_a : '0;
        d     <= abs_b;
        neg_q <= sgn & (a[DIV_W-1] ^ b[DIV_W-1]);
        neg_r <= sgn & a[DIV_W-1];
        dz    <= b == '0;
      end else if (state == DIV_CALC) begin
        cnt <= cnt + 1'b1;
        q   <= {q[DIV_W-2:0], ge};
        r   <= r_next;
      end
    end
  end
  // Divide-by-zero forces an all-ones quotient regardless of signs; remainder falls out as the dividend.
  assign done      = state == DIV_DONE;
  assign quotient  = dz ? '1 : (neg_q ? -q : q);
  assign remainder = neg_r ? -r : r;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: LoongArch32 execute stage - payload register, ALU/MUL/DIV, data-SRAM request, EX->MEM bus.
//  clk, reset       : clock, async active-high reset
//  IDreg_valid      : decode holds a valid instruction
//  ID_ready_go      : decode may hand over
//  IDreg_bus        : decoded instruction (id_bus_t layout)
//  MEM_allow_in     : MEM can accept
//  EX_allow_in      : EX can latch a new instruction
//  EX_ready_go      : EX result complete (low while dividing)
//  EXreg_valid      : qualifies EXreg_bus
//  EXreg_bus        : {ld_ctrl, res_from_mem, rf_we, waddr, pc, result}
//  data_sram_*      : data SRAM request (en, byte strobes, address, lane-replicated data)
//  EX_fwd           : {valid&rf_we, res_from_mem, waddr, result} to the hazard unit
//  Optional DIV_EARLY_TERM_EN is honoured by the divider.
module ex_stage import ex_stage_pkg::*; #(
  parameter int DIV_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  IDreg_valid,
  input  logic                  ID_ready_go,
  input  logic [ID_BUS_LEN-1:0] IDreg_bus,
  input  logic                  MEM_allow_in,
  output logic                  EX_allow_in,
  output logic                  EX_ready_go,
  output logic                  EXreg_valid,
  output logic [EX_BUS_LEN-1:0] EXreg_bus,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_we,
  output logic [31:0]           data_sram_addr,
  output logic [31:0]           data_sram_wdata,
  output logic [EX_FWD_LEN-1:0] EX_fwd
);
  id_bus_t p;
  logic ex_valid, div_done, take;
  logic [31:0] s1, s2, sum, sra, alu_res, mul_res, div_res, result, quo, rem;
  logic [63:0] prod;
  logic [3:0] we_raw;
  assign take = IDreg_valid & ID_ready_go;
  assign EX_ready_go = ~(ex_valid & p.div & ~div_done);
  assign EX_allow_in = ~ex_valid | (EX_ready_go & MEM_allow_in);
  assign EXreg_valid = ex_valid & EX_ready_go;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      p        <= '0;
    end else if (EX_allow_in) begin
      ex_valid <= take;
      if (take) p <= IDreg_bus;
    end
  end
  assign s1  = p.src1;
  assign s2  = p.src2;
  assign sum = s1 + s2;
  assign sra = $signed(s1) >>> s2[4:0];
  assign alu_res = ({32{p.alu_op[0]}}  & sum)
                 | ({32{p.alu_op[1]}}  & (s1 - s2))
                 | ({32{p.alu_op[2]}}  & {31'd0, $signed(s1) < $signed(s2)})
                 | ({32{p.alu_op[3]}}  & {31'd0, s1 < s2})
                 | ({32{p.alu_op[4]}}  & (s1 & s2))
                 | ({32{p.alu_op[5]}}  & ~(s1 | s2))
                 | ({32{p.alu_op[6]}}  & (s1 | s2))
                 | ({32{p.alu_op[7]}}  & (s1 ^ s2))
                 | ({32{p.alu_op[8]}}  & (s1 << s2[4:0]))
                 | ({32{p.alu_op[9]}}  & (s1 >> s2[4:0]))
                 | ({32{p.alu_op[10]}} & sra)
                 | ({32{p.alu_op[11]}} & s2);
  // Low 64 bits of the product of 64-bit extended operands equal the exact signed/unsigned product.
  assign prod = {{32{p.alu_op[1] & s1[31]}}, s1} * {{32{p.alu_op[1] & s2[31]}}, s2};
  assign mul_res = p.alu_op[0] ? prod[31:0] : prod[63:32];
  ex_stage_div #(.DIV_W(DIV_W)) div_unit (
    .clk       (clk),
    .reset     (reset),
    .start     (ex_valid & p.div),
    .sgn       (p.alu_op[0] | p.alu_op[2]),
    .ack       (MEM_allow_in),
    .a         (s1),
    .b         (s2),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );
  assign div_res = (p.alu_op[2] | p.alu_op[3]) ? rem : quo;
  assign result  = p.div ? div_res : (p.mul ? mul_res : alu_res);
  assign data_sram_en    = ex_valid & p.mem_en;
  assign data_sram_addr  = sum;
  assign we_raw = p.st_ctrl[ST_W] ? 4'hF
                : p.st_ctrl[ST_H] ? (sum[1] ? 4'hC : 4'h3)
                : p.st_ctrl[ST_B] ? (4'h1 << sum[1:0]) : 4'h0;
  assign data_sram_we    = data_sram_en ? we_raw : 4'h0;
  assign data_sram_wdata = p.st_ctrl[ST_B] ? {4{p.rkd[7:0]}}
                         : p.st_ctrl[ST_H] ? {2{p.rkd[15:0]}} : p.rkd;
  assign EXreg_bus = {p.ld_ctrl, p.res_from_mem, p.rf_we, p.waddr, p.pc, result};
  assign EX_fwd    = {ex_valid & p.rf_we, p.res_from_mem, p.waddr, result};
endmodule
